// File: rtl/mac_vec.sv
// rtl/mac_vec.sv - pipelined LANES-wide multiply-accumulate dot-product engine
// Purpose: sums cfg_len beats of LANES parallel a*b products into one ACCW-bit
//          result and flags any accumulate step that leaves the ACCW range.
// Ports:
//   clk, rst_n                            clock, asynchronous active-low reset
//   cfg_en, cfg_signed, cfg_len           config strobe, operand mode, beats per result (0 = 2^CNTW)
//   in_valid, in_ready, in_a, in_b        operand beat handshake, lane i at [i*DW +: DW]
//   out_valid, out_ready, out_data, out_ovf  result handshake; data/ovf read 0 while out_valid=0
// Macro: MAC_VEC_SAT_EN - when defined, an overflowing step clamps and locks the accumulator;
//        otherwise the accumulator wraps modulo 2^ACCW.
module mac_vec #(
   parameter int DW    = 8,
   parameter int LANES = 4,
   parameter int ACCW  = 24,
   parameter int CNTW  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_en,
   input  logic                  cfg_signed,
   input  logic [CNTW-1:0]       cfg_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*DW-1:0]   in_a,
   input  logic [LANES*DW-1:0]   in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACCW-1:0]       out_data,
   output logic                  out_ovf
);

   // Product width holds both the unsigned and the signed extremes of DW x DW.
   localparam int PW = 2*DW + 1;
   localparam int SW = PW + $clog2(LANES + 1);
   localparam int WW = ACCW + SW + 1;

   localparam logic signed [WW-1:0] SMAX = {{(WW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
   localparam logic signed [WW-1:0] SMIN = {{(WW-ACCW+1){1'b1}}, {(ACCW-1){1'b0}}};
   localparam logic signed [WW-1:0] UMAX = {{(WW-ACCW){1'b0}}, {ACCW{1'b1}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 cfg_signed_q, cfg_signed_d;
   logic [CNTW-1:0]      cfg_len_q, cfg_len_d;
   logic [CNTW:0]        cnt_q, cnt_d;
   logic [1:0]           drain_q, drain_d;
   logic                 p1_valid_q, p1_valid_d;
   logic signed [PW-1:0] prod_q [LANES];
   logic signed [PW-1:0] prod_d [LANES];
   logic [ACCW-1:0]      acc_q, acc_d;
   logic                 ovf_q, ovf_d;
`ifdef MAC_VEC_SAT_EN
   logic                 sat_q, sat_d;
`endif

   logic                 pipe_idle;
   logic                 cfg_load;
   logic                 take;
   logic                 last_beat;
   logic                 out_fire;
   logic [CNTW:0]        len_full;
   logic [CNTW:0]        cnt_inc;
   logic [DW-1:0]        a_l, b_l;
   logic signed [PW-1:0] ax, bx;
   logic signed [SW-1:0] sum_s;
   logic signed [WW-1:0] acc_x, sum_x, tot;
   logic                 step_ovf;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_en) state_d = RUN;
         RUN:     if (last_beat) state_d = DRAIN;
         // drain_q paces the result so out_valid rises on the third edge after the last beat
         DRAIN:   if (drain_q == 2'd2) state_d = OUT;
         OUT:     if (out_ready) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = {ACCW{1'b0}};
      out_ovf   = 1'b0;
      case (state_q)
         // A reconfiguration cycle refuses data so the new mode applies from beat one.
         RUN: in_ready = !(cfg_en && pipe_idle);
         OUT: begin
            out_valid = 1'b1;
            out_data  = acc_q;
            out_ovf   = ovf_q;
         end
         default: ;
      endcase
   end

   // ---------------- control helpers ----------------
   always_comb begin
      pipe_idle = (cnt_q == {(CNTW+1){1'b0}}) && !p1_valid_q;
      cfg_load  = cfg_en && ((state_q == IDLE) || ((state_q == RUN) && pipe_idle));
      take      = in_valid && in_ready;
      len_full  = (cfg_len_q == {CNTW{1'b0}}) ? {1'b1, {CNTW{1'b0}}} : {1'b0, cfg_len_q};
      cnt_inc   = cnt_q + {{CNTW{1'b0}}, 1'b1};
      last_beat = take && (cnt_inc == len_full);
      out_fire  = (state_q == OUT) && out_ready;
   end

   // ---------------- datapath next state ----------------
   always_comb begin
      cfg_signed_d = cfg_signed_q;
      cfg_len_d    = cfg_len_q;
      cnt_d        = cnt_q;
      drain_d      = 2'd0;
      p1_valid_d   = take;
      acc_d        = acc_q;
      ovf_d        = ovf_q;
`ifdef MAC_VEC_SAT_EN
      sat_d        = sat_q;
`endif
      a_l   = {DW{1'b0}};
      b_l   = {DW{1'b0}};
      ax    = {PW{1'b0}};
      bx    = {PW{1'b0}};
      sum_s = {SW{1'b0}};

      if (cfg_load) begin
         cfg_signed_d = cfg_signed;
         cfg_len_d    = cfg_len;
      end
      if (take) begin
         cnt_d = cnt_inc;
      end
      if (state_q == DRAIN) begin
         drain_d = drain_q + 2'd1;
      end

      // Stage 1: per-lane products, extended according to the latched operand mode.
      for (int i = 0; i < LANES; i++) begin
         a_l       = in_a[i*DW +: DW];
         b_l       = in_b[i*DW +: DW];
         ax        = {{(PW-DW){cfg_signed_q & a_l[DW-1]}}, a_l};
         bx        = {{(PW-DW){cfg_signed_q & b_l[DW-1]}}, b_l};
         prod_d[i] = ax * bx;
      end

      // Stage 2: lane sum plus accumulator, evaluated wide enough to see any overflow.
      for (int i = 0; i < LANES; i++) begin
         sum_s = sum_s + {{(SW-PW){prod_q[i][PW-1]}}, prod_q[i]};
      end
      acc_x    = {{(WW-ACCW){cfg_signed_q & acc_q[ACCW-1]}}, acc_q};
      sum_x    = {{(WW-SW){sum_s[SW-1]}}, sum_s};
      tot      = acc_x + sum_x;
      step_ovf = cfg_signed_q ? ((tot > SMAX) || (tot < SMIN))
                              : ((tot > UMAX) || tot[WW-1]);

      if (p1_valid_q) begin
         ovf_d = ovf_q | step_ovf;
`ifdef MAC_VEC_SAT_EN
         // Once clamped the accumulator is frozen until the result is consumed.
         if (!sat_q) begin
            if (step_ovf) begin
               sat_d = 1'b1;
               if (cfg_signed_q) begin
                  acc_d = tot[WW-1] ? SMIN[ACCW-1:0] : SMAX[ACCW-1:0];
               end else begin
                  acc_d = tot[WW-1] ? {ACCW{1'b0}} : UMAX[ACCW-1:0];
               end
            end else begin
               acc_d = tot[ACCW-1:0];
            end
         end
`else
         acc_d = tot[ACCW-1:0];
`endif
      end

      if (out_fire) begin
         acc_d = {ACCW{1'b0}};
         cnt_d = {(CNTW+1){1'b0}};
         ovf_d = 1'b0;
`ifdef MAC_VEC_SAT_EN
         sat_d = 1'b0;
`endif
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_signed_q <= 1'b0;
         cfg_len_q    <= {CNTW{1'b0}};
         cnt_q        <= {(CNTW+1){1'b0}};
         drain_q      <= 2'd0;
         p1_valid_q   <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= {PW{1'b0}};
         end
         acc_q        <= {ACCW{1'b0}};
         ovf_q        <= 1'b0;
`ifdef MAC_VEC_SAT_EN
         sat_q        <= 1'b0;
`endif
      end else begin
         cfg_signed_q <= cfg_signed_d;
         cfg_len_q    <= cfg_len_d;
         cnt_q        <= cnt_d;
         drain_q      <= drain_d;
         p1_valid_q   <= p1_valid_d;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= prod_d[i];
         end
         acc_q        <= acc_d;
         ovf_q        <= ovf_d;
`ifdef MAC_VEC_SAT_EN
         sat_q        <= sat_d;
`endif
      end
   end

endmodule

// File: tb/tb_mac_vec.sv
// tb/tb_mac_vec.sv - randomized self-checking bench for mac_vec against a dot-product model
module tb_mac_vec;
   localparam int DW    = 8;
   localparam int LANES = 4;
   localparam int ACCW  = 24;
   localparam int CNTW  = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cfg_en;
   logic                cfg_signed;
   logic [CNTW-1:0]     cfg_len;
   logic                in_valid;
   logic                in_ready;
   logic [LANES*DW-1:0] in_a;
   logic [LANES*DW-1:0] in_b;
   logic                out_valid;
   logic                out_ready;
   logic [ACCW-1:0]     out_data;
   logic                out_ovf;

   always #5 clk = ~clk;

   mac_vec #(.DW(DW), .LANES(LANES), .ACCW(ACCW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_en(cfg_en), .cfg_signed(cfg_signed), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];

   // Dot product of the queued beats with plain integer arithmetic.
   function automatic void ref_dot(input bit sgn, output logic [23:0] data, output bit ovf);
      longint acc, s, hi, lo;
      bit sat;
      logic [7:0] ab, bb;
      acc = 0; sat = 0; ovf = 0;
      if (sgn) begin
         hi = (longint'(1) << 23) - 1;
         lo = -(longint'(1) << 23);
      end else begin
         hi = (longint'(1) << 24) - 1;
         lo = 0;
      end
      for (int k = 0; k < qa.size(); k++) begin
         s = 0;
         for (int l = 0; l < 4; l++) begin
            ab = qa[k][l*8 +: 8];
            bb = qb[k][l*8 +: 8];
            if (sgn) s += longint'($signed(ab)) * longint'($signed(bb));
            else     s += longint'(ab) * longint'(bb);
         end
         if (!sat) begin
            acc += s;
            if (acc > hi || acc < lo) begin
               ovf = 1;
`ifdef MAC_VEC_SAT_EN
               acc = (acc > hi) ? hi : lo;
               sat = 1;
`else
               acc = acc & 64'hFFFFFF;
               if (sgn && acc > hi) acc -= (longint'(1) << 24);
`endif
            end
         end
      end
      data = acc[23:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic configure(input bit sgn, input logic [7:0] len, output logic rdy);
      cfg_en = 1'b1; cfg_signed = sgn; cfg_len = len;
      #1;
      rdy = in_ready;
      @(posedge clk);
      #1;
      cfg_en = 1'b0;
      cfg_signed = 1'($urandom);
      cfg_len = 8'($urandom);
   endtask

   task automatic make_beats(input int n, input bit rnd, input logic [31:0] a, input logic [31:0] b);
      qa.delete(); qb.delete();
      for (int k = 0; k < n; k++) begin
         qa.push_back(rnd ? $urandom : a);
         qb.push_back(rnd ? $urandom : b);
      end
   endtask

   task automatic send_beats(input bit gaps, input bit mid_cfg, output bit ok);
      bit acc_ok;
      ok = 1;
      for (int k = 0; k < qa.size(); k++) begin
         acc_ok = 0;
         in_a = qa[k]; in_b = qb[k]; in_valid = 1'b1;
         for (int w = 0; w < 16 && !acc_ok; w++) begin
            #1;
            acc_ok = in_ready;
            @(posedge clk);
            #1;
         end
         if (!acc_ok) ok = 0;
         if (gaps && k != qa.size() - 1) begin
            in_valid = 1'b0;
            if (mid_cfg && k == 0) begin
               cfg_en = 1'b1; cfg_signed = 1'($urandom); cfg_len = 8'd1;
            end
            tick();
            cfg_en = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = -1;
      if (out_valid) lat = 0;
      for (int k = 1; k <= 12 && lat < 0; k++) begin
         tick();
         if (out_valid) lat = k;
      end
   endtask

   task automatic accept_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit seen;
      rst_n = 1'b0; cfg_en = 0; cfg_signed = 0; cfg_len = 0;
      in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
      repeat (3) tick();
      n_vec++; if ({in_ready, out_valid, out_ovf} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {in_ready, out_valid, out_ovf}); end
      n_vec++; if (out_data !== 24'h0) begin n_err++; $display("FAIL reset_data: got %h want 000000", out_data); end
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; seen = 0;
      repeat (4) begin tick(); if (in_ready !== 1'b0) seen = 1; end
      in_valid = 1'b0;
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL idle_ready: got 1 want 0"); end
   endtask

   task automatic test_signed_b2b();
      logic rdy; bit ok; int lat;
      configure(1'b1, 8'd2, rdy);
      n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_cfg_ready: got %b want 0", rdy); end
      make_beats(2, 0, 32'hFEFEFEFE, 32'h03030303);
      send_beats(0, 0, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b want 1", ok); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_drain_ready: got %b want 0", in_ready); end
      wait_result(lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL b2b_latency: got %0d want 3", lat); end
      n_vec++; if (out_data !== 24'hFFFFD0) begin n_err++; $display("FAIL b2b_data: got %h want ffffd0", out_data); end
      n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", out_ovf); end
      accept_out();
      n_vec++; if ({out_valid, out_ovf, out_data} !== 26'h0) begin n_err++; $display("FAIL b2b_after_consume: got %b/%b/%h want 0/0/000000", out_valid, out_ovf, out_data); end
   endtask

   task automatic test_unsigned_single();
      logic rdy; bit ok; int lat;
      configure(1'b0, 8'd1, rdy);
      make_beats(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      send_beats(0, 0, ok);
      wait_result(lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", lat); end
      n_vec++; if ({out_ovf, out_data} !== {1'b0, 24'h03F804}) begin n_err++; $display("FAIL single_result: got %b/%h want 0/03f804", out_ovf, out_data); end
      accept_out();
   endtask

   task automatic test_unsigned_overflow();
      logic rdy; bit ok; int lat; logic [23:0] exp;
`ifdef MAC_VEC_SAT_EN
      exp = 24'hFFFFFF;
`else
      exp = 24'hF80400;
`endif
      configure(1'b0, 8'd0, rdy);
      make_beats(256, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      send_beats(0, 0, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL uovf_accept: got %b want 1", ok); end
      wait_result(lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL uovf_latency: got %0d want 3", lat); end
      n_vec++; if (out_data !== exp) begin n_err++; $display("FAIL uovf_data: got %h want %h", out_data, exp); end
      n_vec++; if (out_ovf !== 1'b1) begin n_err++; $display("FAIL uovf_flag: got %b want 1", out_ovf); end
      accept_out();
   endtask

   task automatic test_signed_overflow();
      logic rdy; bit ok; int lat; logic [23:0] ed; bit eo;
      configure(1'b1, 8'd0, rdy);
      make_beats(256, 0, 32'h80808080, 32'h7F7F7F7F);
      ref_dot(1'b1, ed, eo);
      send_beats(0, 0, ok);
      wait_result(lat);
      n_vec++; if ({out_ovf, out_data} !== {eo, ed}) begin n_err++; $display("FAIL sovf_result: got %b/%h want %b/%h", out_ovf, out_data, eo, ed); end
      accept_out();
   endtask

   task automatic test_backpressure();
      logic rdy; bit ok; int lat; logic [23:0] ed; bit eo;
      configure(1'b1, 8'd3, rdy);
      make_beats(3, 1, 0, 0);
      ref_dot(1'b1, ed, eo);
      send_beats(0, 0, ok);
      wait_result(lat);
      n_vec++; if ({out_ovf, out_data} !== {eo, ed}) begin n_err++; $display("FAIL bp_first: got %b/%h want %b/%h", out_ovf, out_data, eo, ed); end
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_vec++; if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, ed}) begin n_err++; $display("FAIL bp_hold_c%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h", c, out_valid, in_ready, out_data, ed); end
      end
      in_valid = 1'b0;
      accept_out();
      make_beats(3, 1, 0, 0);
      ref_dot(1'b1, ed, eo);
      send_beats(0, 0, ok);
      wait_result(lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL bp_next_latency: got %0d want 3", lat); end
      n_vec++; if ({out_ovf, out_data} !== {eo, ed}) begin n_err++; $display("FAIL bp_next: got %b/%h want %b/%h", out_ovf, out_data, eo, ed); end
      accept_out();
   endtask

   task automatic test_gaps();
      logic rdy; bit ok; int lat;
      configure(1'b1, 8'd4, rdy);
      make_beats(4, 0, 32'hFEFEFEFE, 32'h03030303);
      send_beats(1, 1, ok);
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL gaps_accept: got %b want 1", ok); end
      wait_result(lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL gaps_latency: got %0d want 3", lat); end
      n_vec++; if ({out_ovf, out_data} !== {1'b0, 24'hFFFFA0}) begin n_err++; $display("FAIL gaps_result: got %b/%h want 0/ffffa0", out_ovf, out_data); end
      accept_out();
      send_beats(0, 0, ok);
      wait_result(lat);
      n_vec++; if ({out_ovf, out_data} !== {1'b0, 24'hFFFFA0}) begin n_err++; $display("FAIL gaps_b2b_result: got %b/%h want 0/ffffa0", out_ovf, out_data); end
      accept_out();
   endtask

   task automatic test_random();
      logic rdy; bit ok; int lat; logic [23:0] ed; bit eo; bit sgn; int len;
      for (int it = 0; it < 24; it++) begin
         sgn = 1'($urandom);
         len = $urandom_range(1, 6);
         configure(sgn, 8'(len), rdy);
         n_vec++; if (rdy !== 1'b0) begin n_err++; $display("FAIL rnd%0d_cfg_ready: got %b want 0", it, rdy); end
         make_beats(len, 1, 0, 0);
         ref_dot(sgn, ed, eo);
         send_beats(1'($urandom), 1'($urandom), ok);
         wait_result(lat);
         n_vec++; if (lat !== 3) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 3", it, lat); end
         n_vec++; if ({out_ovf, out_data} !== {eo, ed}) begin n_err++; $display("FAIL rnd%0d_result: got %b/%h want %b/%h", it, out_ovf, out_data, eo, ed); end
         accept_out();
      end
   endtask

   task automatic test_reset_mid();
      logic rdy; bit ok; int lat; logic [23:0] ed; bit eo; bit seen;
      configure(1'b1, 8'd8, rdy);
      make_beats(3, 1, 0, 0);
      send_beats(0, 0, ok);
      rst_n = 1'b0;
      #1;
      n_vec++; if ({in_ready, out_valid, out_ovf, out_data} !== 27'h0) begin n_err++; $display("FAIL rstmid_outputs: got r=%b v=%b o=%b d=%h want all 0", in_ready, out_valid, out_ovf, out_data); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = 1'b1; seen = 0;
      repeat (4) begin tick(); if (in_ready !== 1'b0) seen = 1; end
      in_valid = 1'b0;
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got 1 want 0"); end
      configure(1'b1, 8'd2, rdy);
      make_beats(2, 1, 0, 0);
      ref_dot(1'b1, ed, eo);
      send_beats(0, 0, ok);
      wait_result(lat);
      n_vec++; if ({out_ovf, out_data} !== {eo, ed}) begin n_err++; $display("FAIL rstmid_result: got %b/%h want %b/%h", out_ovf, out_data, eo, ed); end
      accept_out();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_signed_b2b();
      test_unsigned_single();
      test_unsigned_overflow();
      test_signed_overflow();
      test_backpressure();
      test_gaps();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
